// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory port between N_REQ requesters; latches the
// winner's mode/addr, runs the req/gnt/start/rdy handshake and returns rdy or err.
module mem_req_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             cpu_req,
    input  logic [2*N_REQ-1:0]           cpu_mode,
    input  logic [8*N_REQ-1:0]           cpu_addr,
    output logic [N_REQ-1:0]             cpu_gnt,
    output logic [N_REQ-1:0]             cpu_rdy,
    output logic [N_REQ-1:0]             cpu_err,
    output logic [$clog2(N_REQ)-1:0]     owner_id,
    output logic                         busy,
    output logic                         mem_req,
    output logic                         mem_start,
    output logic [1:0]                   mem_mode,
    output logic [7:0]                   mem_addr,
    input  logic                         mem_gnt,
    input  logic                         mem_rdy
);

    localparam int IDW = $clog2(N_REQ);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        START,
        WAIT,
        DONE
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [7:0]     cnt;

    logic           pick_valid;
    logic [IDW-1:0] pick_id;
    logic [IDW:0]   cand;
    logic [1:0]     pick_mode;
    logic [7:0]     pick_addr;

    // First pending requester found walking upward from rr_ptr, wrapping at N_REQ.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(N_REQ)) begin
                cand = cand - (IDW+1)'(N_REQ);
            end
            if (!pick_valid && cpu_req[cand[IDW-1:0]]) begin
                pick_valid = 1'b1;
                pick_id    = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        pick_mode = '0;
        pick_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_id == IDW'(i)) begin
                pick_mode = cpu_mode[2*i +: 2];
                pick_addr = cpu_addr[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            cpu_gnt   <= '0;
            cpu_rdy   <= '0;
            cpu_err   <= '0;
            owner_id  <= '0;
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            mem_start <= 1'b0;
            mem_mode  <= '0;
            mem_addr  <= '0;
        end else begin
            mem_start <= 1'b0;
            cpu_rdy   <= '0;
            cpu_err   <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state    <= REQ;
                        busy     <= 1'b1;
                        mem_req  <= 1'b1;
                        owner_id <= pick_id;
                        cpu_gnt  <= N_REQ'(1) << pick_id;
                        mem_mode <= pick_mode;
                        mem_addr <= pick_addr;
                        cnt      <= '0;
                    end
                end
                // A grant arriving on the final counted cycle still wins over the abort.
                REQ: begin
                    if (mem_gnt) begin
                        state     <= START;
                        mem_start <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        cpu_err <= cpu_gnt;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                START: begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: begin
                    if (mem_rdy) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        cpu_rdy <= cpu_gnt;
                    end else if (cnt == CNT_LAST) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        cpu_err <= cpu_gnt;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    cpu_gnt  <= '0;
                    owner_id <= '0;
                    mem_mode <= '0;
                    mem_addr <= '0;
                    rr_ptr   <= (owner_id == IDW'(N_REQ - 1)) ? '0 : owner_id + 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level round-robin/timeout model.
module tb_mem_req_arbiter;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 15;
    localparam int IDW     = $clog2(N_REQ);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N_REQ-1:0]     cpu_req;
    logic [2*N_REQ-1:0]   cpu_mode;
    logic [8*N_REQ-1:0]   cpu_addr;
    logic [N_REQ-1:0]     cpu_gnt;
    logic [N_REQ-1:0]     cpu_rdy;
    logic [N_REQ-1:0]     cpu_err;
    logic [IDW-1:0]       owner_id;
    logic                 busy;
    logic                 mem_req;
    logic                 mem_start;
    logic [1:0]           mem_mode;
    logic [7:0]           mem_addr;
    logic                 mem_gnt;
    logic                 mem_rdy;

    int tests    = 0;
    int failures = 0;
    int rrPtr    = 0;

    mem_req_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_mode  (cpu_mode),
        .cpu_addr  (cpu_addr),
        .cpu_gnt   (cpu_gnt),
        .cpu_rdy   (cpu_rdy),
        .cpu_err   (cpu_err),
        .owner_id  (owner_id),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_start (mem_start),
        .mem_mode  (mem_mode),
        .mem_addr  (mem_addr),
        .mem_gnt   (mem_gnt),
        .mem_rdy   (mem_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] allOutputs();
        return 32'({cpu_gnt, cpu_rdy, cpu_err, owner_id, busy, mem_req, mem_start, mem_mode, mem_addr});
    endfunction

    task automatic applyStimulus(input logic [N_REQ-1:0] mask);
        cpu_req = mask;
        for (int i = 0; i < N_REQ; i++) begin
            cpu_addr[8*i +: 8] = 8'($urandom);
            cpu_mode[2*i +: 2] = 2'($urandom);
        end
    endtask

    task automatic doReset(input string tag);
        rst_n = 1'b0;
        #1;
        checkOutput(tag, allOutputs(), 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_held"}, allOutputs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rrPtr = 0;
    endtask

    // One full transaction from IDLE. gk/rk: edge (counted from state entry) at which the
    // memory answers; anything beyond TIMEOUT means it never answers.
    task automatic runTxn(input int gk, input int rk, input bit midChange, output int ownerSeen);
        int         win;
        int         reqEdges;
        int         waitEdges;
        int         starts;
        int         inflightBad;
        bit         gntOk;
        bit         rdyOk;
        bit         expOk;
        logic [7:0] expAddr;
        logic [1:0] expMode;

        win = -1;
        for (int i = 0; i < N_REQ; i++) begin
            int idx;
            idx = (rrPtr + i) % N_REQ;
            if (win < 0 && cpu_req[idx]) win = idx;
        end
        if (win < 0) win = 0;
        expAddr = cpu_addr[8*win +: 8];
        expMode = cpu_mode[2*win +: 2];

        checkOutput("idle_before_req", 32'({busy, mem_req, cpu_rdy, cpu_err}), 32'd0);
        mem_gnt = 1'b0;
        mem_rdy = 1'b0;
        tick();
        ownerSeen = int'(owner_id);
        checkOutput("gnt_onehot", 32'(cpu_gnt), 32'(1) << win);
        checkOutput("owner_id", 32'(owner_id), 32'(win));
        checkOutput("mem_addr_latch", 32'(mem_addr), 32'(expAddr));
        checkOutput("mem_mode_latch", 32'(mem_mode), 32'(expMode));
        checkOutput("req_entry", 32'({busy, mem_req, mem_start, |cpu_rdy, |cpu_err}), 32'b11000);

        starts      = 0;
        inflightBad = 0;
        gntOk       = (gk <= TIMEOUT);
        reqEdges    = gntOk ? gk : TIMEOUT;
        for (int c = 1; c <= reqEdges; c++) begin
            mem_gnt = (c == gk);
            mem_rdy = 1'($urandom);
            tick();
            if (mem_start) starts++;
            if ((c < reqEdges || gntOk) &&
                (busy !== 1'b1 || mem_req !== 1'b1 || cpu_rdy !== '0 || cpu_err !== '0))
                inflightBad++;
        end

        rdyOk = 1'b0;
        if (gntOk) begin
            mem_gnt = 1'($urandom);
            mem_rdy = 1'($urandom);
            tick();
            if (mem_start) starts++;
            if (busy !== 1'b1 || mem_req !== 1'b1 || cpu_rdy !== '0 || cpu_err !== '0)
                inflightBad++;
            rdyOk     = (rk <= TIMEOUT);
            waitEdges = rdyOk ? rk : TIMEOUT;
            for (int c = 1; c <= waitEdges; c++) begin
                mem_rdy = (c == rk);
                mem_gnt = 1'($urandom);
                if (midChange && c == 1) begin
                    cpu_req[win]          = 1'b0;
                    cpu_addr[8*win +: 8]  = ~expAddr;
                    cpu_mode[2*win +: 2]  = ~expMode;
                end
                tick();
                if (mem_start) starts++;
                if (c < waitEdges &&
                    (busy !== 1'b1 || mem_req !== 1'b1 || cpu_rdy !== '0 || cpu_err !== '0))
                    inflightBad++;
            end
        end
        mem_gnt = 1'b0;
        mem_rdy = 1'b0;

        expOk = gntOk && rdyOk;
        checkOutput("cpu_rdy", 32'(cpu_rdy), expOk ? (32'(1) << win) : 32'd0);
        checkOutput("cpu_err", 32'(cpu_err), expOk ? 32'd0 : (32'(1) << win));
        checkOutput("done_busy_memreq", 32'({busy, mem_req}), 32'b10);
        checkOutput("done_gnt", 32'(cpu_gnt), 32'(1) << win);
        checkOutput("done_addr_hold", 32'({mem_mode, mem_addr}), 32'({expMode, expAddr}));
        checkOutput("start_pulses", 32'(starts), gntOk ? 32'd1 : 32'd0);
        checkOutput("inflight_cycles", 32'(inflightBad), 32'd0);
        rrPtr = (win + 1) % N_REQ;

        tick();
        checkOutput("idle_after_done", allOutputs(), 32'd0);
    endtask

    initial begin
        int own;
        cpu_req  = '0;
        cpu_mode = '0;
        cpu_addr = '0;
        mem_gnt  = 1'b0;
        mem_rdy  = 1'b0;
        rst_n    = 1'b1;
        #2;
        doReset("reset_init");

        // Round-robin with all requesters held and an immediate memory
        for (int k = 0; k < 5; k++) begin
            applyStimulus('1);
            runTxn(1, 1, 1'b0, own);
            checkOutput("rr_order", 32'(own), 32'(k % N_REQ));
        end

        // Single request with fixed address and mode
        applyStimulus(4'b0001);
        cpu_addr[7:0] = 8'h3C;
        cpu_mode[1:0] = 2'd2;
        runTxn(2, 2, 1'b0, own);
        checkOutput("single_owner", 32'(own), 32'd0);

        // Pointer wrap after requester 3
        applyStimulus(4'b1000);
        runTxn(1, 1, 1'b0, own);
        applyStimulus(4'b1001);
        runTxn(1, 1, 1'b0, own);
        checkOutput("wrap_first", 32'(own), 32'd0);
        applyStimulus(4'b1001);
        runTxn(1, 1, 1'b0, own);
        checkOutput("wrap_second", 32'(own), 32'd3);

        // Timeouts in REQ and in WAIT, then answers on the last allowed cycle
        applyStimulus(4'b0010);
        runTxn(TIMEOUT + 1, 1, 1'b0, own);
        applyStimulus(4'b0100);
        runTxn(1, TIMEOUT + 1, 1'b0, own);
        applyStimulus(4'b1111);
        runTxn(TIMEOUT, TIMEOUT, 1'b0, own);

        // Owner drops request and changes address during WAIT
        applyStimulus(4'b0011);
        runTxn(1, 3, 1'b1, own);

        // Reset in the middle of WAIT
        applyStimulus(4'b0100);
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        tick();
        tick();
        #2;
        doReset("reset_in_wait");
        applyStimulus(4'b0100);
        runTxn(1, 1, 1'b0, own);
        checkOutput("post_reset_owner", 32'(own), 32'd2);

        // Reset in IDLE must bring the pointer back to 0
        doReset("reset_idle");
        applyStimulus(4'b1001);
        runTxn(1, 2, 1'b0, own);
        checkOutput("ptr_reset_order", 32'(own), 32'd0);

        // Randomized transactions
        for (int k = 0; k < 25; k++) begin
            applyStimulus(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)));
            runTxn($urandom_range(1, TIMEOUT + 2), $urandom_range(1, TIMEOUT + 2),
                   1'($urandom_range(0, 1)), own);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Round-robin arbiter and transaction sequencer that shares one memMod-style memory port (req/gnt/start/mode/addr/rdy handshake) between N_REQ cpuMod-style requesters. It sits between the CPU-side request lines and the single memory port. It latches the winning requester's mode/addr, runs the memory handshake, and returns a one-cycle completion or timeout-error pulse to the winner. The shared 8-bit data bus is not routed through this block; owners steer it using `cpu_gnt`/`owner_id`.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 15: max cycles spent in REQ or WAIT before abort, 1..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `cpu_req` in N_REQ: per-requester request level, held until `cpu_rdy`/`cpu_err`.
- `cpu_mode` in 2*N_REQ: mode of requester i at bits [2i+1:2i].
- `cpu_addr` in 8*N_REQ: address of requester i at bits [8i+7:8i].
- `cpu_gnt` out N_REQ: one-hot owner of the memory port; all-zero when idle.
- `cpu_rdy` out N_REQ: one-cycle completion pulse to the owner.
- `cpu_err` out N_REQ: one-cycle timeout pulse to the owner.
- `owner_id` out clog2(N_REQ): index of the current owner; 0 when idle.
- `busy` out 1: high in every state except IDLE.
- `mem_req` out 1: request to the memory.
- `mem_start` out 1: one-cycle transfer start.
- `mem_mode` out 2: latched mode.
- `mem_addr` out 8: latched address.
- `mem_gnt` in 1: memory grants the port.
- `mem_rdy` in 1: memory completes the transfer.

## Operation
- FSM states: IDLE, REQ, START, WAIT, DONE.
- IDLE:
  - If any `cpu_req` is set, pick the winner by round-robin and go to REQ.
  - Search order starts at `rr_ptr` and wraps modulo N_REQ.
  - On the transition, register `owner_id`, `cpu_gnt`, and the winner's `mem_mode`/`mem_addr`.
- REQ: `mem_req`=1. On `mem_gnt`=1, go to START.
- START: `mem_start`=1 for exactly this cycle, then go to WAIT unconditionally. `mem_rdy` is ignored in START.
- WAIT: on `mem_rdy`=1, go to DONE with status ok.
- DONE:
  - Pulse `cpu_rdy[owner]`, or `cpu_err[owner]` if the transaction aborted.
  - Drop `mem_req`.
  - Set `rr_ptr` = (owner+1) mod N_REQ.
  - Go to IDLE.
- Timeout:
  - An 8-bit counter clears on entry to REQ and on entry to WAIT, and increments each cycle spent in those states.
  - If the counter reaches TIMEOUT-1 with no `mem_gnt` (in REQ) or no `mem_rdy` (in WAIT), go to DONE with status err.
  - `rr_ptr` advances after an error as well.
- `mem_req` is high in REQ, START and WAIT only.
- `cpu_gnt`/`owner_id` are valid from REQ through DONE inclusive.
- `mem_mode`/`mem_addr` are held constant from REQ through DONE and are 0 in IDLE.
- Requester inputs are sampled only at the IDLE→REQ transition:
  - Owner dropping `cpu_req` mid-transaction: ignored; the transaction completes normally.
  - Owner changing addr/mode mid-transaction: ignored.
- A non-owner's `cpu_req` is only considered in IDLE. No requester wins twice in a row while another requester is pending.
- `mem_gnt` outside REQ and `mem_rdy` outside WAIT have no effect.
- Reset (asynchronous, any state):
  - State returns to IDLE and `rr_ptr` to 0.
  - The counter clears.
  - All outputs go to 0.
  - An in-flight transaction is dropped with no `cpu_rdy`/`cpu_err` pulse.
- All outputs are registered.

## Timing
- Request seen in IDLE at edge t: `cpu_gnt`/`mem_req` high after edge t.
- `mem_gnt` high at edge t+1: `mem_start` high in cycle t+1..t+2, i.e. one cycle.
- `mem_rdy` high at the first WAIT edge: `cpu_rdy` pulses in the following cycle.
- Minimum request-to-`cpu_rdy` latency: 4 cycles.
- DONE→IDLE takes 1 cycle, so there is 1 idle cycle between back-to-back transactions. Minimum issue period is 5 cycles.
- Worst case without timeout: TIMEOUT cycles in REQ plus TIMEOUT cycles in WAIT.
- `cpu_rdy` and `cpu_err` are never both set. At most one bit of each vector is set.

## Test plan
- Single request:
  - Stimulus: `cpu_req`=0001, addr0=0x3C, mode0=2; `mem_gnt` answers after 1 cycle, `mem_rdy` after 2 WAIT cycles.
  - Required: `mem_addr`=0x3C, `mem_mode`=2, exactly one `mem_start` pulse, then `cpu_rdy`=0001 for one cycle, then `busy`=0.
- Round-robin:
  - Stimulus: `cpu_req`=1111 held; memory answers immediately.
  - Required: grant order 0,1,2,3,0; each grant preceded by 1 idle cycle.
- Pointer wrap/fairness:
  - Stimulus: after requester 3 is served, assert `cpu_req`=1001.
  - Required: requester 0 wins, then requester 3.
- Timeout:
  - Stimulus: TIMEOUT=15; `mem_gnt` never asserts.
  - Required: `cpu_err[owner]` pulses exactly 15 cycles after REQ entry, `mem_start` never asserts, `mem_req` drops.
  - Repeat with `mem_rdy` withheld in WAIT: same required response.
- Mid-transaction changes:
  - Stimulus: owner drops `cpu_req` and changes addr during WAIT.
  - Required: `mem_addr` unchanged and `cpu_rdy` still pulses.
- Reset:
  - Stimulus: `rst_n` low for 1 cycle during WAIT.
  - Required: all outputs 0 immediately (asynchronously); after release, a pending `cpu_req`=0100 wins with `rr_ptr`=0 ordering; no stale `cpu_rdy`.
